// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: data-memory req/gnt/rvalid transaction, lane steering and load extension.
// Optional misaligned-access trap is enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_mem_write_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_load_data_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic              req_r;
    logic              we_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [3:0]        wstrb_r;
    logic [2:0]        funct3_r;
    logic [1:0]        lane_r;
    logic [XLEN-1:0]   load_data_r;
    logic              misalign_r;

    logic              memop_s;
    logic              is_load_s;
    logic [1:0]        size_s;
    logic              misalign_s;
    logic              stall_s;
    logic              wb_valid_s;

    // Access size: 00 byte, 01 half, 10 word (unused encodings behave as word)
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: access_size = 2'b00;
            3'b001, 3'b101: access_size = 2'b01;
            default:        access_size = 2'b10;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   store_strobe = 4'b0001 << lane;
            2'b01:   store_strobe = lane[1] ? 4'b1100 : 4'b0011;
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = word;
        endcase
    endfunction

    // Decode of the current EX/MEM slot; read wins when both read and write are set
    always_comb begin
        memop_s   = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
        is_load_s = ex_mem_read_i;
        size_s    = access_size(ex_funct3_i);
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Halves need addr[0]=0, words need addr[1:0]=0
    always_comb begin
        if (size_s == 2'b01) begin
            misalign_s = ex_addr_i[0];
        end else if (size_s == 2'b10) begin
            misalign_s = (ex_addr_i[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Transaction FSM; bus fields are captured on IDLE->REQ so the slot may change underneath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= 4'b0000;
            funct3_r    <= 3'b000;
            lane_r      <= 2'b00;
            load_data_r <= '0;
            misalign_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (memop_s && misalign_s) begin
                        state_r     <= DONE;
                        misalign_r  <= 1'b1;
                        load_data_r <= '0;
                    end else if (memop_s) begin
                        state_r  <= REQ;
                        req_r    <= 1'b1;
                        we_r     <= ~is_load_s;
                        addr_r   <= {ex_addr_i[XLEN-1:2], 2'b00};
                        wdata_r  <= store_lanes(size_s, ex_wdata_i);
                        wstrb_r  <= store_strobe(size_s, ex_addr_i[1:0]);
                        funct3_r <= ex_funct3_i;
                        lane_r   <= ex_addr_i[1:0];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        req_r   <= 1'b0;
                        state_r <= we_r ? DONE : RESP;
                    end else begin
                        state_r <= REQ;
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        load_data_r <= load_extend(funct3_r, lane_r, dmem_rdata_i);
                        state_r     <= DONE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    misalign_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    req_r      <= 1'b0;
                    misalign_r <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline handshake: non-memory ops complete in the same cycle; reset forces both low
    always_comb begin
        stall_s    = rst_n & memop_s & (state_r != DONE);
        wb_valid_s = rst_n & ex_valid_i & (~memop_s | (state_r == DONE));
    end

    assign stall_o        = stall_s;
    assign wb_valid_o     = wb_valid_s;
    assign wb_load_data_o = load_data_r;
    assign dmem_req_o     = req_r;
    assign dmem_we_o      = we_r;
    assign dmem_addr_o    = addr_r;
    assign dmem_wdata_o   = wdata_r;
    assign dmem_wstrb_o   = wstrb_r;
    assign misalign_o     = misalign_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, stores, loads, wait states, reset, misalign.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_mem_read_i;
    logic        ex_mem_write_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] wb_load_data_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        misalign_o;

    int          total;
    int          bad;
    logic [31:0] exp_ld;

    mem_access_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid_i),
        .ex_mem_read_i  (ex_mem_read_i),
        .ex_mem_write_i (ex_mem_write_i),
        .ex_funct3_i    (ex_funct3_i),
        .ex_addr_i      (ex_addr_i),
        .ex_wdata_i     (ex_wdata_i),
        .stall_o        (stall_o),
        .wb_valid_o     (wb_valid_o),
        .wb_load_data_o (wb_load_data_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_wstrb_o   (dmem_wstrb_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .misalign_o     (misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slot();
        ex_valid_i     = 1'b0;
        ex_mem_read_i  = 1'b0;
        ex_mem_write_i = 1'b0;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] e_addr, input logic [31:0] e_wdata,
                             input logic [3:0] e_strb, input int gnt_wait);
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b1;
        ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = data;
        #2;
        chk("st_c0_stall", stall_o, 1);
        chk("st_c0_wbv", wb_valid_o, 0);
        chk("st_c0_req", dmem_req_o, 0);
        step(); #2;
        chk("st_req", dmem_req_o, 1);
        chk("st_we", dmem_we_o, 1);
        chk("st_addr", dmem_addr_o, e_addr);
        chk("st_wdata", dmem_wdata_o, e_wdata);
        chk("st_wstrb", dmem_wstrb_o, e_strb);
        chk("st_req_stall", stall_o, 1);
        for (int i = 0; i < gnt_wait; i++) begin
            step(); #2;
            chk("st_wait_req", dmem_req_o, 1);
            chk("st_wait_addr", dmem_addr_o, e_addr);
            chk("st_wait_stall", stall_o, 1);
        end
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #2;
        chk("st_done_wbv", wb_valid_o, 1);
        chk("st_done_stall", stall_o, 0);
        chk("st_done_req", dmem_req_o, 0);
        step();
        idle_slot();
        #2;
        chk("st_after_wbv", wb_valid_o, 0);
        chk("st_after_req", dmem_req_o, 0);
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] e_addr, input logic [31:0] e_data,
                            input int gnt_wait, input int rv_wait);
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_mem_write_i = 1'b0;
        ex_funct3_i = f3; ex_addr_i = addr; ex_wdata_i = 32'h0BAD_0BAD;
        #2;
        chk("ld_c0_stall", stall_o, 1);
        chk("ld_c0_wbv", wb_valid_o, 0);
        step(); #2;
        chk("ld_req", dmem_req_o, 1);
        chk("ld_we", dmem_we_o, 0);
        chk("ld_addr", dmem_addr_o, e_addr);
        for (int i = 0; i < gnt_wait; i++) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = 32'h5A5A_5A5A;
            step();
            dmem_rvalid_i = 1'b0;
            #2;
            chk("ld_wait_req", dmem_req_o, 1);
            chk("ld_wait_stall", stall_o, 1);
        end
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #2;
        chk("ld_resp_req", dmem_req_o, 0);
        chk("ld_resp_stall", stall_o, 1);
        chk("ld_resp_wbv", wb_valid_o, 0);
        chk("ld_resp_data_old", wb_load_data_o, exp_ld);
        for (int i = 0; i < rv_wait; i++) begin
            step(); #2;
            chk("ld_rwait_stall", stall_o, 1);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        step();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        #2;
        exp_ld = e_data;
        chk("ld_done_wbv", wb_valid_o, 1);
        chk("ld_done_stall", stall_o, 0);
        chk("ld_done_data", wb_load_data_o, exp_ld);
        chk("ld_done_mis", misalign_o, 0);
        step();
        idle_slot();
        #2;
        chk("ld_after_wbv", wb_valid_o, 0);
        chk("ld_after_data", wb_load_data_o, exp_ld);
    endtask

    initial begin
        total = 0; bad = 0; exp_ld = 32'h0000_0000;
        rst_n = 1'b0;
        idle_slot();
        ex_funct3_i = 3'b000; ex_addr_i = 32'h0; ex_wdata_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;

        // Reset state, including a memop presented while reset is held
        #3;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_data", wb_load_data_o, 0);
        chk("rst_mis", misalign_o, 0);
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1;
        #1;
        chk("rst_memop_stall", stall_o, 0);
        chk("rst_memop_wbv", wb_valid_o, 0);
        idle_slot();
        step();
        rst_n = 1'b1;
        step();

        // ADD passes through with no memory activity
        ex_valid_i = 1'b1;
        #2;
        chk("add_wbv", wb_valid_o, 1);
        chk("add_stall", stall_o, 0);
        chk("add_req", dmem_req_o, 0);
        step(); #2;
        chk("add_c1_req", dmem_req_o, 0);
        chk("add_c1_wbv", wb_valid_o, 1);
        idle_slot();
        #1;
        chk("bubble_wbv", wb_valid_o, 0);
        step();

        // Stores
        run_store(3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000, 0);
        run_store(3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0000_0100, 32'hABCD_ABCD, 4'b1100, 1);
        run_store(3'b000, 32'h0000_0101, 32'h0000_0077, 32'h0000_0100, 32'h7777_7777, 4'b0010, 0);
        run_store(3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 0);

        // Loads
        run_load(3'b000, 32'h0000_0102, 32'h12F0_3456, 32'h0000_0100, 32'hFFFF_FFF0, 2, 0);
        run_load(3'b100, 32'h0000_0102, 32'h12F0_3456, 32'h0000_0100, 32'h0000_00F0, 0, 0);
        run_load(3'b001, 32'h0000_0202, 32'h8001_7FFF, 32'h0000_0200, 32'hFFFF_8001, 0, 0);
        run_load(3'b010, 32'h0000_0204, 32'h8001_7FFF, 32'h0000_0204, 32'h8001_7FFF, 0, 1);
        run_load(3'b101, 32'h0000_0200, 32'h8001_7FFF, 32'h0000_0200, 32'h0000_7FFF, 0, 0);
        run_load(3'b000, 32'h0000_0200, 32'h8001_7F85, 32'h0000_0200, 32'hFFFF_FF85, 0, 0);
        run_load(3'b111, 32'h0000_0208, 32'h1357_2468, 32'h0000_0208, 32'h1357_2468, 1, 0);

        // Slot invalidated mid-transaction: request still completes, DONE gives no writeback
        ex_valid_i = 1'b1; ex_mem_write_i = 1'b1; ex_funct3_i = 3'b010;
        ex_addr_i = 32'h0000_010C; ex_wdata_i = 32'h1122_3344;
        step();
        idle_slot();
        #2;
        chk("drop_req", dmem_req_o, 1);
        chk("drop_stall", stall_o, 0);
        chk("drop_wbv", wb_valid_o, 0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #2;
        chk("drop_done_wbv", wb_valid_o, 0);
        chk("drop_done_req", dmem_req_o, 0);
        step(); #2;
        chk("drop_idle_req", dmem_req_o, 0);

        // Misaligned word load
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_funct3_i = 3'b010; ex_addr_i = 32'h0000_0106;
        #2;
        chk("mis_c0_req", dmem_req_o, 0);
        chk("mis_c0_stall", stall_o, 1);
        step(); #2;
        exp_ld = 32'h0000_0000;
        chk("mis_c1_req", dmem_req_o, 0);
        chk("mis_c1_flag", misalign_o, 1);
        chk("mis_c1_wbv", wb_valid_o, 1);
        chk("mis_c1_stall", stall_o, 0);
        chk("mis_c1_data", wb_load_data_o, exp_ld);
        step();
        idle_slot();
        #2;
        chk("mis_c2_flag", misalign_o, 0);
        chk("mis_c2_req", dmem_req_o, 0);
`else
        run_load(3'b010, 32'h0000_0106, 32'hAABB_CCDD, 32'h0000_0104, 32'hAABB_CCDD, 0, 0);
        chk("mis_off_flag", misalign_o, 0);
`endif

        // Asynchronous reset while waiting for rvalid; late rvalid must be dropped
        ex_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_funct3_i = 3'b010; ex_addr_i = 32'h0000_0300;
        step();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        #2;
        chk("rr_resp_stall", stall_o, 1);
        rst_n = 1'b0;
        #1;
        exp_ld = 32'h0000_0000;
        chk("rr_req", dmem_req_o, 0);
        chk("rr_stall", stall_o, 0);
        chk("rr_wbv", wb_valid_o, 0);
        chk("rr_data", wb_load_data_o, exp_ld);
        chk("rr_mis", misalign_o, 0);
        idle_slot();
        step();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_5555;
        step();
        dmem_rvalid_i = 1'b0;
        #2;
        chk("rr_late_data", wb_load_data_o, exp_ld);
        chk("rr_late_wbv", wb_valid_o, 0);
        chk("rr_late_req", dmem_req_o, 0);
        chk("rr_late_stall", stall_o, 0);
        step(); #2;
        chk("rr_late_data2", wb_load_data_o, exp_ld);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
